// File: rtl/clock_divider_pkg.sv
// Shared constants for the programmable clock divider bank.
package clock_divider_pkg;

    localparam int unsigned CNT_W_DEFAULT = 27;
    localparam int unsigned DEFAULT_DIV   = 67108864;

    // Divisors for slow_out at the named rate from a 100 MHz board clock.
    localparam int unsigned DIV_1HZ       = 50_000_000;
    localparam int unsigned DIV_1KHZ      = 50_000;

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: wrap counter, pending divisor, square-wave and strobe outputs.
module clock_divider_channel
    import clock_divider_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEFAULT,
    parameter int unsigned RST_DIV = DEFAULT_DIV
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic             sync_i,
    output logic             slow_o,
    output logic             tick_o,
    output logic             pend_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic             pend_q, pend_d;
    logic             slow_q, slow_d;
    logic             tick_q, tick_d;
    logic             halted_c;
    logic             wrap_c;

    assign halted_c = (div_act_q == '0);
    assign wrap_c   = enable_i && (cnt_q == div_act_q - CNT_W'(1));

    // Next-state: sync realigns, halted waits for a load, running counts and wraps.
    always_comb begin
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        slow_d     = slow_q;
        tick_d     = 1'b0;

        if (sync_i) begin
            cnt_d  = '0;
            slow_d = 1'b0;
            pend_d = 1'b0;
            if (load_i) begin
                div_act_d = div_i;
            end else if (pend_q) begin
                div_act_d = div_pend_q;
            end
        end else if (halted_c) begin
            cnt_d = '0;
            if (load_i) begin
                div_act_d = div_i;
            end
        end else if (wrap_c) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            slow_d = ~slow_q;
            pend_d = 1'b0;
            // A load arriving on the wrap edge supersedes any older pending divisor.
            if (load_i) begin
                div_act_d = div_i;
            end else if (pend_q) begin
                div_act_d = div_pend_q;
            end
        end else begin
            if (enable_i) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (load_i) begin
                div_pend_d = div_i;
                pend_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q      <= '0;
            div_act_q  <= CNT_W'(RST_DIV);
            div_pend_q <= CNT_W'(RST_DIV);
            pend_q     <= 1'b0;
            slow_q     <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            slow_q     <= slow_d;
            tick_q     <= tick_d;
        end
    end

    assign slow_o = slow_q;
    assign tick_o = tick_q;
    assign pend_o = pend_q;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of independent runtime-programmable clock dividers with a shared phase-align strobe.
module clock_divider_bank #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = clock_divider_pkg::CNT_W_DEFAULT,
    parameter int unsigned DEFAULT_DIV = clock_divider_pkg::DEFAULT_DIV
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*CNT_W-1:0] div_in,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       slow_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       pend
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clock_divider_channel #(
            .CNT_W   (CNT_W),
            .RST_DIV (DEFAULT_DIV)
        ) u_ch (
            .clock_i  (clock),
            .reset_i  (reset),
            .enable_i (enable[i]),
            .load_i   (load[i]),
            .div_i    (div_in[i*CNT_W +: CNT_W]),
            .sync_i   (sync),
            .slow_o   (slow_out[i]),
            .tick_o   (tick[i]),
            .pend_o   (pend[i])
        );
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Randomised scoreboard bench for clock_divider_bank against a cycle-level reference model.
module tb_clock_divider_bank;

    localparam int NCH = 2;
    localparam int CW  = 4;
    localparam int DD  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    enable, load;
    logic [NCH*CW-1:0] div_in;
    logic              sync;
    logic [NCH-1:0]    slow_out, tick, pend;

    clock_divider_bank #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DD)) dut (
        .clock(clk), .reset(reset), .enable(enable), .load(load), .div_in(div_in),
        .sync(sync), .slow_out(slow_out), .tick(tick), .pend(pend)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] slow;
        logic [NCH-1:0] tick;
        logic [NCH-1:0] pend;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: per channel, a phase position within a period of length d.
    int m_pos[NCH], m_d[NCH], m_pd[NCH];
    bit m_pend[NCH], m_slow[NCH], m_tick[NCH];

    task automatic model_step(input bit rst, input bit sy, input logic [NCH-1:0] en,
                              input logic [NCH-1:0] ld, input logic [NCH*CW-1:0] din);
        for (int i = 0; i < NCH; i++) begin
            int nv;
            nv = int'(din[i*CW +: CW]);
            m_tick[i] = 1'b0;
            if (rst) begin
                m_pos[i] = 0; m_d[i] = DD; m_pd[i] = DD; m_pend[i] = 0; m_slow[i] = 0;
            end else if (sy) begin
                m_pos[i] = 0; m_slow[i] = 0;
                if (ld[i]) m_d[i] = nv;
                else if (m_pend[i]) m_d[i] = m_pd[i];
                m_pend[i] = 0;
            end else if (m_d[i] == 0) begin
                if (ld[i]) m_d[i] = nv;
            end else if (en[i] && m_pos[i] + 1 == m_d[i]) begin
                // Period complete: strobe, toggle, adopt the newest divisor.
                m_pos[i] = 0; m_tick[i] = 1; m_slow[i] = !m_slow[i];
                if (ld[i]) m_d[i] = nv;
                else if (m_pend[i]) m_d[i] = m_pd[i];
                m_pend[i] = 0;
            end else begin
                if (en[i]) m_pos[i] = m_pos[i] + 1;
                if (ld[i]) begin m_pd[i] = nv; m_pend[i] = 1; end
            end
        end
    endtask

    // Drive one cycle of stimulus and queue the response expected after the next edge.
    task automatic step(input bit rst, input bit sy, input logic [NCH-1:0] en,
                        input logic [NCH-1:0] ld, input logic [NCH*CW-1:0] din);
        exp_t e;
        @(negedge clk);
        reset = rst; sync = sy; enable = en; load = ld; div_in = din;
        model_step(rst, sy, en, ld, din);
        for (int i = 0; i < NCH; i++) begin
            e.slow[i] = m_slow[i]; e.tick[i] = m_tick[i]; e.pend[i] = m_pend[i];
        end
        exp_q.push_back(e);
    endtask

    task automatic run(input int n, input logic [NCH-1:0] en);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, en, '0, '0);
    endtask

    task automatic check_now(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b", name, $time, got, want);
        end
    endtask

    // Monitor: every clock edge presents an output word; compare it with the queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                total++;
                if (slow_out !== e.slow || tick !== e.tick || pend !== e.pend) begin
                    bad++;
                    $display("FAIL scoreboard cyc=%0d got slow=%b tick=%b pend=%b want slow=%b tick=%b pend=%b",
                             cyc, slow_out, tick, pend, e.slow, e.tick, e.pend);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; sync = 1'b0; enable = '0; load = '0; div_in = '0;

        // 1: basic period-3 run on ch0 with absolute expectations.
        step(1, 0, 2'b00, 2'b00, '0);
        @(posedge clk); #1;
        check_now("reset_slow", slow_out[0], 1'b0);
        check_now("reset_tick", tick[0], 1'b0);
        check_now("reset_pend", pend[0], 1'b0);
        for (int k = 1; k <= 9; k++) begin
            step(0, 0, 2'b01, 2'b00, '0);
            @(posedge clk); #1;
            check_now("s1_tick", tick[0], (k % 3) == 0);
            check_now("s1_slow", slow_out[0], ((k / 3) % 2) == 1);
            check_now("s1_ch1_idle", tick[1] | slow_out[1], 1'b0);
        end

        // 2: pending load of 5 applied at the next wrap.
        step(1, 0, 2'b00, 2'b00, '0);
        step(0, 0, 2'b01, 2'b00, '0);
        step(0, 0, 2'b01, 2'b01, 8'h05);
        @(posedge clk); #1;
        check_now("s2_pend_set", pend[0], 1'b1);
        run(12, 2'b01);

        // 3: load 0 mid-period halts after the period; load 2 restarts.
        step(0, 0, 2'b01, 2'b01, 8'h00);
        run(10, 2'b01);
        step(0, 0, 2'b01, 2'b01, 8'h02);
        run(8, 2'b01);

        // 4: sync realigns two channels at different phases.
        step(1, 0, 2'b00, 2'b00, '0);
        run(2, 2'b01);
        step(0, 1, 2'b11, 2'b00, '0);
        run(9, 2'b11);

        // 5: enable gap of 4 cycles at cnt=1.
        step(1, 0, 2'b00, 2'b00, '0);
        run(1, 2'b01);
        run(4, 2'b00);
        run(8, 2'b01);

        // 6: reset discards a pending divisor of 7.
        step(1, 0, 2'b00, 2'b00, '0);
        step(0, 0, 2'b01, 2'b00, '0);
        step(0, 0, 2'b01, 2'b01, 8'h07);
        step(1, 0, 2'b01, 2'b00, '0);
        @(posedge clk); #1;
        check_now("s6_pend_clr", pend[0], 1'b0);
        check_now("s6_slow_clr", slow_out[0], 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 2'b01, 2'b00, '0);
            @(posedge clk); #1;
            check_now("s6_period3", tick[0], k == 3);
        end

        // Randomised traffic with small divisors, including 0 and 1.
        for (int k = 0; k < 800; k++) begin
            logic [NCH-1:0]    en, ld;
            logic [NCH*CW-1:0] din;
            for (int i = 0; i < NCH; i++) begin
                en[i] = ($urandom_range(0, 9) != 0);
                ld[i] = ($urandom_range(0, 11) == 0);
                din[i*CW +: CW] = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 15))
                                                              : CW'($urandom_range(0, 5));
            end
            step($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0, en, ld, din);
        end

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            total++; bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_divider_bank.md
Name: clock_divider_bank

Overview:
- Bank of NUM_CH independent, runtime-programmable clock dividers driven from the board clock.
- Each channel produces two outputs from one counter:
  - a 50%-duty toggling "slow clock" (slow_out);
  - a one-cycle strobe (tick) at every counter wrap.
- Replaces the fixed power-of-two slow-clock generators in lab tasks: blink rates, debounce sampling, display refresh.
- Divisors can be changed glitch-free while running, and all channels can be phase-aligned with one strobe.

Parameters:
- NUM_CH, 4, number of independent divider channels.
- CNT_W, 27, counter/divisor width in bits.
- DEFAULT_DIV, 67108864, divisor loaded at reset; must be < 2^CNT_W. 2^26 gives a slow_out of about 0.75 Hz at 100 MHz.

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  NUM_CH  per-channel run enable.
- load  in  NUM_CH  per-channel divisor load strobe.
- div_in  in  NUM_CH*CNT_W  packed divisors; channel i uses bits [i*CNT_W +: CNT_W].
- sync  in  1  global phase-align strobe.
- slow_out  out  NUM_CH  divided square wave; period 2*D cycles.
- tick  out  NUM_CH  one-cycle pulse every D enabled cycles.
- pend  out  NUM_CH  a loaded divisor is waiting for the next wrap.

Behaviour:
- Per-channel state:
  - cnt[CNT_W]
  - div_act[CNT_W], the active divisor D
  - div_pend[CNT_W]
  - pend
  - slow_out, tick
- All outputs are registered.
- Reset values: cnt=0, div_act=DEFAULT_DIV, div_pend=DEFAULT_DIV, pend=0, slow_out=0, tick=0.
- Priority per edge: reset > sync > run/load.
- sync=1:
  - every channel: cnt<=0, slow_out<=0, tick<=0;
  - if pend: div_act<=div_pend, pend<=0;
  - a load on the same edge is applied directly to div_act;
  - enable is ignored on this edge.
- Halted channel (div_act==0):
  - cnt holds at 0; slow_out holds its value; tick=0.
  - load: div_act<=div_in slice, cnt<=0, pend stays 0.
  - The channel restarts on the next edge.
- Running channel with enable=1:
  - Wrap edge (cnt==div_act-1): cnt<=0, tick<=1, slow_out<=~slow_out.
    - If load is also high: div_act<=div_in slice, pend<=0. The load value wins over any older pending value.
    - Else if pend: div_act<=div_pend, pend<=0.
  - Otherwise: cnt<=cnt+1, tick<=0.
- Running channel with enable=0:
  - cnt, slow_out and div_act hold; tick<=0.
- Load on a running channel, not on a wrap edge:
  - div_pend<=div_in slice, pend<=1.
  - A later load before the wrap overwrites div_pend.
  - Loads are accepted while the channel is disabled.
- A new divisor only takes effect at a wrap, so cnt never exceeds div_act-1 and no runt pulse is produced.
- Latency:
  - With enable held high from the cycle after reset, the first tick is high in cycle D (D edges after reset release).
  - tick repeats every D cycles; slow_out toggles on the same edges as tick.
- D=1: tick is high continuously; slow_out toggles every cycle.
- D=0 loaded via a pending update: the channel completes its current period, then halts.

Decomposition:
- Package clock_divider_pkg holds:
  - CNT_W_DEFAULT, DEFAULT_DIV;
  - named board-rate constants: DIV_1HZ=50_000_000 and DIV_1KHZ=50_000 for slow_out at 100 MHz.
- Sub-module clock_divider_channel implements one channel's counter, pending register, slow_out and tick.
- The top level generate-instantiates NUM_CH channels, slices div_in, and fans out sync and reset.

Test Plan:
All scenarios use NUM_CH=2, CNT_W=4, DEFAULT_DIV=3.
1. Release reset, enable[0]=1 -> tick[0] high in cycles 3,6,9; slow_out[0] goes 0→1 at cycle 3 and 1→0 at cycle 6; channel 1 (disabled) stays 0.
2. Ch0 running, load[0] with div_in=5 when cnt=1 -> pend[0]=1 until the wrap at cycle 3; next ticks at 8 and 13; pend[0]=0 after the wrap.
3. Load 0 mid-period, then after the halt load 2 -> the current period completes, then no ticks and slow_out holds; after load 2, ticks every 2 cycles starting 2 cycles later.
4. Ch0 cnt=2, ch1 cnt=0, D=3 on both, pulse sync -> both cnt=0 and slow_out=0; subsequent ticks coincide on both channels.
5. Ch0 running, enable[0]=0 for 4 cycles at cnt=1 -> no tick during the gap; the next tick is delayed exactly 4 cycles.
6. Load 7 on ch0 (pend=1), assert reset mid-period -> all outputs 0, pend=0, div_act=3; the next period is 3, not 7.
